// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and its helpers.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int ARB_NUM_REQ_DEF    = 4;
    localparam int ARB_DATA_WIDTH_DEF = 16;
    localparam int ARB_MAX_BURST_DEF  = 4;
    localparam int ARB_STAT_W         = 16;
    localparam int ARB_CNT_W          = 4;

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin picker: first valid index at or above rr_ptr_i, wrapping.
module rr_priority_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_valid_o
);

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        logic [IDX_W-1:0] idx_s;
        idx_s       = rr_ptr_i;
        winner_o    = rr_ptr_i;
        any_valid_o = |req_valid_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s    = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            winner_o = req_valid_i[idx_s] ? idx_s : winner_o;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester accept counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ_DEF,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEF,
    parameter int MAX_BURST  = ARB_MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    input  logic                          err_clr,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          burst_active,
    output logic                          overflow_err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*ARB_STAT_W-1:0] stat_accept_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ARB_CNT_W-1:0] MAX_BURST_C = ARB_CNT_W'(MAX_BURST);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ARB_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   ovf_err_q, ovf_err_d;

    logic [NUM_REQ-1:0]     req_ready_s;
    logic [IDX_W-1:0]       winner_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic                   any_valid_s;
    logic                   stall_s;
    logic                   accept_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (winner_s),
        .any_valid_o (any_valid_s)
    );

    // The registered write still in flight counts against the last free slot.
    assign stall_s = fifo_full | (fifo_almostfull & wr_en_q);

    // Arbitration FSM, write-path next state and sticky overflow flag.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        req_ready_s = '0;
        sel_idx_s   = grant_q;
        case (state_q)
            IDLE: begin
                sel_idx_s = winner_s;
                if (any_valid_s && !stall_s) begin
                    req_ready_s[winner_s] = 1'b1;
                    grant_d               = winner_s;
                    burst_cnt_d           = ARB_CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = next_idx(winner_s);
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (stall_s) begin
                    state_d = BURST;
                end else if (!req_valid[grant_q]) begin
                    req_ready_s[grant_q] = 1'b1;
                    state_d              = IDLE;
                    rr_ptr_d             = next_idx(grant_q);
                end else begin
                    req_ready_s[grant_q] = 1'b1;
                    burst_cnt_d          = burst_cnt_q + ARB_CNT_W'(1);
                    if (burst_cnt_q + ARB_CNT_W'(1) == MAX_BURST_C) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(grant_q);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept_s = |(req_valid & req_ready_s);
        wr_en_d  = accept_s;
        if (accept_s) begin
            data_d = req_data[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            data_d = data_q;
        end

        if (err_clr) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q | fifo_overflow;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign req_ready    = req_ready_s;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_q;
    assign burst_active = (state_q == BURST);
    assign overflow_err = ovf_err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [ARB_STAT_W-1:0] stat_q [NUM_REQ];

    // Saturating per-requester accept counters, cleared together with the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (err_clr) begin
                    stat_q[i] <= '0;
                end else if (req_valid[i] && req_ready_s[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end else begin
                    stat_q[i] <= stat_q[i];
                end
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        stat_accept_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_accept_cnt[i*ARB_STAT_W +: ARB_STAT_W] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (MAX_BURST=4 main DUT, MAX_BURST=2 order DUT).
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic          drain;
    logic          ovf_force;
    logic          err_clr;

    logic [NR-1:0] rdy1, rdy2;
    logic [DW-1:0] d1, d2;
    logic          we1, we2;
    logic [1:0]    gid1, gid2;
    logic          ba1, ba2, oe1, oe2;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0] stat1, stat2;
`endif

    int            fifo_cnt;
    logic          fifo_full_m, fifo_af_m, fifo_ovf_m;
    logic [11:0]   seq_q [NR];
    int            log2[$];
    int            wr_pulses = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            base;
    int            exp_order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .fifo_data_in(d1), .fifo_wr_en(we1),
        .fifo_full(fifo_full_m), .fifo_almostfull(fifo_af_m), .fifo_overflow(fifo_ovf_m),
        .err_clr(err_clr), .grant_id(gid1), .burst_active(ba1), .overflow_err(oe1)
`ifdef FIFO_ARB_STATS_EN
        , .stat_accept_cnt(stat1)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy2), .fifo_data_in(d2), .fifo_wr_en(we2),
        .fifo_full(1'b0), .fifo_almostfull(1'b0), .fifo_overflow(1'b0),
        .err_clr(err_clr), .grant_id(gid2), .burst_active(ba2), .overflow_err(oe2)
`ifdef FIFO_ARB_STATS_EN
        , .stat_accept_cnt(stat2)
`endif
    );

    // Depth-8 FIFO occupancy model; in drain mode every word is read out immediately.
    assign fifo_full_m = (fifo_cnt == 8);
    assign fifo_af_m   = (fifo_cnt == 7);
    assign fifo_ovf_m  = ovf_force | (we1 & fifo_full_m);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_cnt <= 0;
        else if (we1 && !drain && fifo_cnt < 8) fifo_cnt <= fifo_cnt + 1;
    end

    // Producers: requester i offers {i, sequence} and advances on acceptance by the main DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) seq_q[i] <= 12'd0;
        end else begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && rdy1[i]) seq_q[i] <= seq_q[i] + 12'd1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {4'(i), seq_q[i]};
    end

    always @(posedge clk) begin
        if (we1) wr_pulses <= wr_pulses + 1;
        if (rst_n)
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && rdy2[i]) log2.push_back(i);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        err_clr = 1'b0;
        ovf_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drain = 1'b1;
        do_reset();
        chk("rst_wr_en", 32'(we1), 32'd0);
        chk("rst_data", 32'(d1), 32'd0);
        chk("rst_grant", 32'(gid1), 32'd0);
        chk("rst_ovf", 32'(oe1), 32'd0);
        chk("rst_burst", 32'(ba1), 32'd0);
        chk("rst_ready", 32'(rdy1), 32'd0);

        // Single requester streaming: back-to-back bursts with no gaps.
        req_valid = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("t1_wr_en_%0d", k), 32'(we1), 32'd1);
            chk($sformatf("t1_data_%0d", k), 32'(d1), 32'(k - 1));
            chk($sformatf("t1_grant_%0d", k), 32'(gid1), 32'd0);
            if (k == 4) chk("t1_burst_end", 32'(ba1), 32'd0);
            if (k == 5) chk("t1_burst_restart", 32'(ba1), 32'd1);
        end
        req_valid = '0;

        // All requesters valid, MAX_BURST=2: strict pairwise rotation.
        do_reset();
        base = log2.size();
        req_valid = 4'b1111;
        cyc(10);
        req_valid = '0;
        chk("t2_accept_count", 32'(log2.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            if (base + i < log2.size())
                chk($sformatf("t2_order_%0d", i), 32'(log2[base + i]), 32'(exp_order[i]));

        // Undrained depth-8 FIFO: exactly 8 writes, then throttled.
        drain = 1'b0;
        do_reset();
        base = wr_pulses;
        for (int k = 0; k < 20; k++) begin
            req_valid = {3'b000, (seq_q[0] < 12'd10)};
            cyc(1);
        end
        chk("t3_wr_pulses", 32'(wr_pulses - base), 32'd8);
        chk("t3_ready_low", 32'(rdy1[0]), 32'd0);
        chk("t3_ovf_err", 32'(oe1), 32'd0);
        chk("t3_fifo_cnt", 32'(fifo_cnt), 32'd8);
        chk("t3_words_taken", 32'(seq_q[0]), 32'd8);
        req_valid = '0;
        drain = 1'b1;

        // Grantee drops valid after one word: one bubble, then requester 2.
        do_reset();
        req_valid = 4'b0010;
        cyc(1);
        chk("t4_grant1", 32'(gid1), 32'd1);
        chk("t4_data1", 32'(d1), 32'h1000);
        chk("t4_burst1", 32'(ba1), 32'd1);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready_burst", 32'(rdy1), 32'b0010);
        cyc(1);
        chk("t4_bubble_wr_en", 32'(we1), 32'd0);
        chk("t4_bubble_idle", 32'(ba1), 32'd0);
        chk("t4_ready_req2", 32'(rdy1), 32'b0100);
        cyc(1);
        chk("t4_grant2", 32'(gid1), 32'd2);
        chk("t4_wr_en2", 32'(we1), 32'd1);
        chk("t4_data2", 32'(d1), 32'h2000);

        // Asynchronous reset in the middle of a requester-3 burst.
        do_reset();
        req_valid = 4'b1000;
        cyc(2);
        chk("t5_grant3", 32'(gid1), 32'd3);
        chk("t5_wr_en_pre", 32'(we1), 32'd1);
        chk("t5_data_pre", 32'(d1), 32'h3001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en_rst", 32'(we1), 32'd0);
        chk("t5_grant_rst", 32'(gid1), 32'd0);
        chk("t5_burst_rst", 32'(ba1), 32'd0);
        req_valid = 4'b1010;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);
        chk("t5_grant_after", 32'(gid1), 32'd1);
        chk("t5_data_after", 32'(d1), 32'h1000);
        req_valid = '0;

        // Sticky overflow error and clear priority.
        do_reset();
        ovf_force = 1'b1;
        cyc(1);
        ovf_force = 1'b0;
        chk("t6_set", 32'(oe1), 32'd1);
        cyc(3);
        chk("t6_hold", 32'(oe1), 32'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t6_clear", 32'(oe1), 32'd0);
        ovf_force = 1'b1;
        err_clr = 1'b1;
        cyc(1);
        ovf_force = 1'b0;
        err_clr = 1'b0;
        chk("t6_clr_priority_idle", 32'(oe1), 32'd0);
        ovf_force = 1'b1;
        cyc(1);
        chk("t6_set_again", 32'(oe1), 32'd1);
        err_clr = 1'b1;
        cyc(1);
        ovf_force = 1'b0;
        err_clr = 1'b0;
        chk("t6_clr_priority_set", 32'(oe1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
